// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the 32x32 register file.
//
// ALU results are single-cycle and get priority on the one write port. LSU
// results are buffered in a small FIFO. Each FIFO entry is written when the
// ALU does not issue. Per-register write order is kept by stalling an ALU
// result whose destination is still pending in the FIFO, or is being pushed
// into it this cycle. Pending values (FIFO entries and the write-back stage)
// are forwarded to the two read ports, newest first.
//
// Handshakes:
//   ALU: alu_valid is the offer. alu_stall=1 means the result was not taken
//        this cycle, and the ALU must hold it and offer it again. A result
//        with alu_addr==0 is always taken and then discarded.
//   LSU: the result transfers when lsu_valid & lsu_ready. lsu_ready depends
//        only on the registered occupancy. A result with lsu_addr==0
//        transfers but is discarded.
module regfile_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [AW-1:0]              alu_addr,
  input  logic [DW-1:0]              alu_data,
  output logic                       alu_stall,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [AW-1:0]              lsu_addr,
  input  logic [DW-1:0]              lsu_data,
  output logic                       wb_rw,
  output logic [AW-1:0]              wb_addr,
  output logic [DW-1:0]              wb_data,
  input  logic [AW-1:0]              rd_addr1,
  input  logic [AW-1:0]              rd_addr2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [DW-1:0]              fwd_data1,
  output logic [DW-1:0]              fwd_data2,
  output logic [$clog2(DEPTH):0]     pend_cnt
);

  localparam int PW = $clog2(DEPTH);

  // FIFO storage and pointers.
  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic          push_acc;
  logic          push_store;
  logic          do_pop;
  logic          issue_alu;
  logic          fifo_match_alu;
  logic          hit1_raw;
  logic          hit2_raw;
  logic [DW-1:0] data1_raw;
  logic [DW-1:0] data2_raw;

  // The FIFO can accept only when it is not full by the registered count.
  // A pop in the same cycle does not make room.
  assign lsu_ready  = (count != (PW+1)'(DEPTH));
  assign push_acc   = lsu_valid & lsu_ready;
  assign push_store = push_acc & (lsu_addr != '0);

  // Scan the valid entries, oldest to newest, so that later matches override
  // earlier ones. The write-back stage is the oldest candidate.
  always_comb begin
    fifo_match_alu = 1'b0;
    hit1_raw       = wb_rw && (wb_addr == rd_addr1);
    hit2_raw       = wb_rw && (wb_addr == rd_addr2);
    data1_raw      = wb_data;
    data2_raw      = wb_data;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < count) begin
        if (fifo_addr[head + PW'(k)] == alu_addr) begin
          fifo_match_alu = 1'b1;
        end
        if (fifo_addr[head + PW'(k)] == rd_addr1) begin
          hit1_raw  = 1'b1;
          data1_raw = fifo_data[head + PW'(k)];
        end
        if (fifo_addr[head + PW'(k)] == rd_addr2) begin
          hit2_raw  = 1'b1;
          data2_raw = fifo_data[head + PW'(k)];
        end
      end
    end
  end

  // r0 is never forwarded. The data output is zero when there is no hit.
  assign fwd_hit1  = hit1_raw & (rd_addr1 != '0);
  assign fwd_hit2  = hit2_raw & (rd_addr2 != '0);
  assign fwd_data1 = fwd_hit1 ? data1_raw : '0;
  assign fwd_data2 = fwd_hit2 ? data2_raw : '0;

  // Stall the ALU if its destination is still owed an older LSU write.
  assign alu_stall = alu_valid & (alu_addr != '0) &
                     (fifo_match_alu | (push_store & (lsu_addr == alu_addr)));

  // The ALU wins the write port. Otherwise the FIFO head drains. There is no
  // bypass, because count is registered.
  assign issue_alu = alu_valid & ~alu_stall & (alu_addr != '0);
  assign do_pop    = ~issue_alu & (count != '0);

  // FIFO payload: written at the tail on a stored push. No reset is needed,
  // because only entries counted as valid are ever read.
  always_ff @(posedge clk) begin
    if (push_store) begin
      fifo_addr[tail] <= lsu_addr;
      fifo_data[tail] <= lsu_data;
    end
  end

  // FIFO pointers and occupancy. A reset discards everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_store) tail <= tail + 1'b1;
      if (do_pop)     head <= head + 1'b1;
      count <= count + (PW+1)'(push_store) - (PW+1)'(do_pop);
    end
  end

  // Write-back stage: at most one registered write per cycle. Address and
  // data hold their value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rw   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_rw <= issue_alu | do_pop;
      if (issue_alu) begin
        wb_addr <= alu_addr;
        wb_data <= alu_data;
      end else if (do_pop) begin
        wb_addr <= fifo_addr[head];
        wb_data <= fifo_data[head];
      end
    end
  end

  assign pend_cnt = count;

endmodule
